// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns memory-stage load/store requests into single bus
// transactions. It stalls the pipeline while an access is in flight and aborts on bus error or timeout.
module dmem_bridge #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dmemen_i,
    input  logic [3:0]  dmemwe_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt;
    logic        finish;
    logic        fail;
    logic        expired;

    // Counter starts at 0 in the first REQ cycle, so TIMEOUT busy cycles end here.
    assign expired = (cnt == TIMEOUT - 8'd1);

    always_comb begin
        state_nxt = state;
        finish    = 1'b0;
        fail      = 1'b0;
        case (state)
            IDLE: begin
                if (dmemen_i) state_nxt = REQ;
            end
            REQ: begin
                if (bus_gnt_i && bus_rvalid_i) begin
                    finish    = 1'b1;
                    fail      = bus_err_i;
                    state_nxt = DONE;
                end else if (expired) begin
                    finish    = 1'b1;
                    fail      = 1'b1;
                    state_nxt = DONE;
                end else if (bus_gnt_i) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus_rvalid_i) begin
                    finish    = 1'b1;
                    fail      = bus_err_i;
                    state_nxt = DONE;
                end else if (expired) begin
                    finish    = 1'b1;
                    fail      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign stall_o   = ((state == IDLE) && dmemen_i) || (state == REQ) || (state == WAIT);
    assign bus_req_o = (state == REQ);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            bus_we_o    <= 1'b0;
            bus_be_o    <= '0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            rdata_o     <= '0;
            err_o       <= 1'b0;
        end else begin
            state <= state_nxt;
            err_o <= finish && fail;
            if ((state == IDLE) && dmemen_i) begin
                cnt         <= '0;
                bus_addr_o  <= {addr_i[31:2], 2'b00};
                bus_be_o    <= (|dmemwe_i) ? dmemwe_i : 4'hF;
                bus_we_o    <= |dmemwe_i;
                bus_wdata_o <= wdata_i;
            end else if ((state == REQ) || (state == WAIT)) begin
                cnt <= cnt + 8'd1;
            end
            // Errors and timeouts zero the returned word; good stores leave it alone.
            if (finish) begin
                if (fail) begin
                    rdata_o <= '0;
                end else if (!bus_we_o) begin
                    rdata_o <= bus_rdata_i;
                end
            end
        end
    end

endmodule
